// File: rtl/redirect_ctrl.sv
// Pipeline redirect / PC-sequencing controller: arbitrates next-PC sources, drives PC write enable
// and pipeline flushes, tracks run/halt state and saturating branch statistics counters.
module redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcen,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        id_jump,
  input  logic [31:0] id_target,
  input  logic        ex_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        halt_req,
  input  logic        go,
  output logic [31:0] next_pc,
  output logic        pc_we,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        halted,
  output logic [15:0] uncondsum,
  output logic [15:0] condsum,
  output logic [15:0] condsuccsum
);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e state_q, state_d;
  logic   uncond_inc, cond_inc, succ_inc;

  always_comb begin
    state_d    = state_q;
    next_pc    = pc_in;
    pc_we      = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    uncond_inc = 1'b0;
    cond_inc   = 1'b0;
    succ_inc   = 1'b0;
    if (rst) begin
      next_pc    = RESET_PC;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (pcen) begin
      unique case (state_q)
        StRun: begin
          // Priority follows instruction age: WB halt, then EX branch, then ID jump.
          cond_inc = ex_branch & ~halt_req;
          succ_inc = ex_branch & ex_taken & ~halt_req;
          if (halt_req) begin
            state_d = StHalt;
          end else if (ex_branch && ex_taken) begin
            next_pc    = ex_target;
            pc_we      = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (id_jump && !stall) begin
            next_pc    = id_target;
            pc_we      = 1'b1;
            flush_ifid = 1'b1;
            uncond_inc = 1'b1;
          end else if (!stall) begin
            next_pc = pc_in + 32'd4;
            pc_we   = 1'b1;
          end
        end
        StHalt: begin
          if (go) state_d = StRun;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      uncondsum   <= 16'd0;
      condsum     <= 16'd0;
      condsuccsum <= 16'd0;
    end else begin
      state_q <= state_d;
      if (uncond_inc && uncondsum != 16'hFFFF) uncondsum <= uncondsum + 16'd1;
      if (cond_inc && condsum != 16'hFFFF) condsum <= condsum + 16'd1;
      if (succ_inc && condsuccsum != 16'hFFFF) condsuccsum <= condsuccsum + 16'd1;
    end
  end

  assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: directed scenarios plus random traffic checked against a
// rule-level reference model; a monitor pops expectations at each falling edge.
module tb_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcen = 1'b0, stall = 1'b0, id_jump = 1'b0, ex_branch = 1'b0, ex_taken = 1'b0;
  logic        halt_req = 1'b0, go = 1'b0;
  logic [31:0] pc_in = 32'h3000, id_target = 32'h0, ex_target = 32'h0;
  logic [31:0] next_pc;
  logic        pc_we, flush_ifid, flush_idex, halted;
  logic [15:0] uncondsum, condsum, condsuccsum;

  redirect_ctrl dut (
    .clk(clk), .rst(rst), .pcen(pcen), .pc_in(pc_in), .stall(stall), .id_jump(id_jump),
    .id_target(id_target), .ex_branch(ex_branch), .ex_taken(ex_taken), .ex_target(ex_target),
    .halt_req(halt_req), .go(go), .next_pc(next_pc), .pc_we(pc_we), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .halted(halted), .uncondsum(uncondsum), .condsum(condsum),
    .condsuccsum(condsuccsum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          chk_pc;
    logic        we, fi, fe, hl;
    logic [15:0] unc, cnd, suc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state, as seen after the most recent clock edge.
  bit m_halted = 0;
  int m_unc = 0, m_cnd = 0, m_suc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat_inc(int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic drive(bit r, bit p, logic [31:0] pc, bit st, bit ij, logic [31:0] it, bit eb,
                       bit et, logic [31:0] etg, bit hr, bit g);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; pcen = p; pc_in = pc; stall = st; id_jump = ij; id_target = it;
    ex_branch = eb; ex_taken = et; ex_target = etg; halt_req = hr; go = g;
    if (r) begin
      m_halted = 0; m_unc = 0; m_cnd = 0; m_suc = 0;
    end
    e.hl = m_halted; e.unc = m_unc[15:0]; e.cnd = m_cnd[15:0]; e.suc = m_suc[15:0];
    e.pc = pc; e.chk_pc = 0; e.we = 0; e.fi = 0; e.fe = 0;
    if (r) begin
      e.pc = 32'h0000_3000; e.chk_pc = 1; e.fi = 1; e.fe = 1;
    end else if (p && m_halted) begin
      if (g) m_halted = 0;
    end else if (p) begin
      if (eb && !hr) m_cnd = sat_inc(m_cnd);
      if (eb && et && !hr) m_suc = sat_inc(m_suc);
      e.chk_pc = 1;
      if (hr) begin
        m_halted = 1;
      end else if (eb && et) begin
        e.pc = etg; e.we = 1; e.fi = 1; e.fe = 1;
      end else if (ij && !st) begin
        e.pc = it; e.we = 1; e.fi = 1;
        m_unc = sat_inc(m_unc);
      end else if (!st) begin
        e.pc = pc + 32'd4; e.we = 1;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(logic [31:0] pc);
    drive(0, 1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_pc) chk("next_pc", next_pc, e.pc);
        chk("pc_we", {31'd0, pc_we}, {31'd0, e.we});
        chk("flush_ifid", {31'd0, flush_ifid}, {31'd0, e.fi});
        chk("flush_idex", {31'd0, flush_idex}, {31'd0, e.fe});
        chk("halted", {31'd0, halted}, {31'd0, e.hl});
        chk("uncondsum", {16'd0, uncondsum}, {16'd0, e.unc});
        chk("condsum", {16'd0, condsum}, {16'd0, e.cnd});
        chk("condsuccsum", {16'd0, condsuccsum}, {16'd0, e.suc});
      end
    end
  end

  initial begin : stimulus
    logic [31:0] pc;
    // Reset and plain sequential fetch.
    drive(1, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(32'h3000);
    // Jump accepted, then jump under stall.
    drive(0, 1, 32'h3004, 0, 1, 32'h3040, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h3040, 1, 1, 32'h3080, 0, 0, 0, 0, 0);
    // Taken branch beats jump and stall.
    drive(1, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h3044, 1, 1, 32'h3200, 1, 1, 32'h3100, 0, 0);
    // Not-taken branch.
    drive(0, 1, 32'h3100, 0, 0, 0, 1, 0, 32'h3300, 0, 0);
    // Halt with taken branch in the same cycle: halt wins.
    drive(0, 1, 32'h3104, 0, 1, 32'h3400, 1, 1, 32'h3500, 1, 0);
    drive(0, 1, 32'h3104, 0, 1, 32'h3400, 1, 1, 32'h3500, 0, 0);
    drive(0, 0, 32'h3104, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 1, 32'h3104, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(32'h3104);
    drive(0, 1, 32'h3108, 0, 0, 0, 0, 0, 0, 0, 1);   // go while running is ignored
    idle(32'hFFFF_FFFC);                              // modulo wrap
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, pc,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end
    // Saturation of condsum via not-taken branches from a clean state.
    drive(1, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) drive(0, 1, 32'h3000, 0, 0, 0, 1, 0, 32'h0, 0, 0);
    @(negedge clk);
    #1;
    chk("condsum_saturated", {16'd0, condsum}, 32'h0000_FFFF);
    // Asynchronous reset mid-run clears counters before the next edge.
    drive(1, 1, 32'h3000, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
